// File: rtl/voice_env_mixer.sv
// Per-voice linear attack/release envelopes, voice mix and a 1-bit PWM audio output.
// Optional feature: define SIGMA_DELTA_EN to replace the PWM comparator with a first-order sigma-delta modulator.
module voice_env_mixer #(
  parameter  int VOICES       = 4,
  parameter  int ENV_WIDTH    = 4,
  parameter  int ENV_PRESCALE = 1024,
  parameter  int PWM_WIDTH    = 8,
  localparam int SUM_WIDTH    = ENV_WIDTH + $clog2(VOICES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [VOICES-1:0]    tone,
  input  logic [VOICES-1:0]    gate,
  output logic                 pwm_out,
  output logic [VOICES-1:0]    voice_active,
  output logic [SUM_WIDTH-1:0] sample
);

  localparam int                   PRE_W      = $clog2(ENV_PRESCALE);
  localparam logic [PRE_W-1:0]     PRE_LAST   = PRE_W'(ENV_PRESCALE - 1);
  localparam logic [ENV_WIDTH-1:0] ENV_MAX    = '1;
  localparam logic [ENV_WIDTH-1:0] ENV_ONE    = ENV_WIDTH'(1);
  localparam int                   DUTY_SHIFT = PWM_WIDTH - SUM_WIDTH;

  typedef enum logic [1:0] {
    ENV_IDLE,
    ENV_ATTACK,
    ENV_SUSTAIN,
    ENV_RELEASE
  } env_state_e;

  function automatic logic [ENV_WIDTH-1:0] level_up(input logic [ENV_WIDTH-1:0] l);
    return (l == ENV_MAX) ? ENV_MAX : l + ENV_ONE;
  endfunction

  function automatic logic [ENV_WIDTH-1:0] level_down(input logic [ENV_WIDTH-1:0] l);
    return (l == '0) ? '0 : l - ENV_ONE;
  endfunction

  // Input stage
  logic [VOICES-1:0] tone_q, gate_q;

  // Envelope prescaler
  logic [PRE_W-1:0] presc_q, presc_d;
  logic             env_tick;

  // Per-voice envelope
  env_state_e           state_q [VOICES];
  env_state_e           state_d [VOICES];
  logic [ENV_WIDTH-1:0] level_q [VOICES];
  logic [ENV_WIDTH-1:0] level_d [VOICES];
  logic [VOICES-1:0]    active_q, active_d;

  // Mix and PWM
  logic [SUM_WIDTH-1:0] mix;
  logic [SUM_WIDTH-1:0] sample_q, sample_d;
  logic [PWM_WIDTH-1:0] pcnt_q, pcnt_d;
  logic [PWM_WIDTH-1:0] duty_q, duty_d;
  logic                 pcnt_wrap;
  logic                 pwm_q, pwm_d;

  assign env_tick = (presc_q == PRE_LAST);
  assign presc_d  = env_tick ? '0 : presc_q + PRE_W'(1);

  // NOTE: every signal written in a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    for (int v = 0; v < VOICES; v++) begin
      state_d[v] = state_q[v];
      level_d[v] = level_q[v];
      if (env_tick) begin
        case (state_q[v])
          ENV_IDLE: begin
            if (gate_q[v]) begin
              level_d[v] = ENV_ONE;
              state_d[v] = (ENV_ONE == ENV_MAX) ? ENV_SUSTAIN : ENV_ATTACK;
            end
          end
          ENV_ATTACK, ENV_RELEASE: begin
            // A gate flip reverses direction from the current level, never restarting from 0.
            if (gate_q[v]) begin
              level_d[v] = level_up(level_q[v]);
              state_d[v] = (level_d[v] == ENV_MAX) ? ENV_SUSTAIN : ENV_ATTACK;
            end else begin
              level_d[v] = level_down(level_q[v]);
              state_d[v] = (level_d[v] == '0) ? ENV_IDLE : ENV_RELEASE;
            end
          end
          ENV_SUSTAIN: begin
            if (!gate_q[v]) begin
              level_d[v] = level_down(level_q[v]);
              state_d[v] = (level_d[v] == '0) ? ENV_IDLE : ENV_RELEASE;
            end
          end
          default: begin
            level_d[v] = '0;
            state_d[v] = ENV_IDLE;
          end
        endcase
      end
      active_d[v] = (level_d[v] != '0);
    end
  end

  always_comb begin
    mix = '0;
    for (int v = 0; v < VOICES; v++) begin
      if (tone_q[v]) mix = mix + SUM_WIDTH'(level_q[v]);
    end
  end

  // Duty and sample only move at the counter wrap, so a period never mixes two duty values.
  assign pcnt_d    = pcnt_q + PWM_WIDTH'(1);
  assign pcnt_wrap = (pcnt_q == '1);
  assign duty_d    = pcnt_wrap ? (PWM_WIDTH'(mix) << DUTY_SHIFT) : duty_q;
  assign sample_d  = pcnt_wrap ? mix : sample_q;

`ifdef SIGMA_DELTA_EN
  // Only the low bits are stored; the carry goes straight into the output register.
  logic [PWM_WIDTH-1:0] acc_q;
  logic [PWM_WIDTH:0]   acc_sum;

  assign acc_sum = {1'b0, acc_q} + {1'b0, duty_q};
  assign pwm_d   = acc_sum[PWM_WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_sum[PWM_WIDTH-1:0];
    end
  end
`else
  assign pwm_d = (pcnt_d < duty_d);
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tone_q   <= '0;
      gate_q   <= '0;
      presc_q  <= '0;
      active_q <= '0;
      pcnt_q   <= '0;
      duty_q   <= '0;
      sample_q <= '0;
      pwm_q    <= 1'b0;
      // NOTE: the per-voice arrays are a handful of flops rather than a RAM, so resetting them is cheap and required.
      for (int v = 0; v < VOICES; v++) begin
        state_q[v] <= ENV_IDLE;
        level_q[v] <= '0;
      end
    end else begin
      tone_q   <= tone;
      gate_q   <= gate;
      presc_q  <= presc_d;
      active_q <= active_d;
      pcnt_q   <= pcnt_d;
      duty_q   <= duty_d;
      sample_q <= sample_d;
      pwm_q    <= pwm_d;
      for (int v = 0; v < VOICES; v++) begin
        state_q[v] <= state_d[v];
        level_q[v] <= level_d[v];
      end
    end
  end

  assign pwm_out      = pwm_q;
  assign voice_active = active_q;
  assign sample       = sample_q;

endmodule

// File: tb/tb_voice_env_mixer.sv
// Scoreboard bench for voice_env_mixer: a driver issues per-tick stimulus and queues expectations,
// a monitor pops them against voice_active, sample and per-period PWM high counts.
module tb_voice_env_mixer;

  localparam int VOICES       = 4;
  localparam int ENV_WIDTH    = 4;
  localparam int ENV_PRESCALE = 4;
  localparam int PWM_WIDTH    = 8;
  localparam int SUM_WIDTH    = ENV_WIDTH + $clog2(VOICES);
  localparam int ENV_MAX      = (1 << ENV_WIDTH) - 1;
  localparam int PERIOD       = 1 << PWM_WIDTH;
  localparam int SPP          = PERIOD / ENV_PRESCALE;
  localparam int N_PERIODS    = 16;
  localparam int N_SLOTS      = N_PERIODS * SPP;
  localparam int N_CYCLES     = N_SLOTS * ENV_PRESCALE + PERIOD + 40;
`ifdef SIGMA_DELTA_EN
  localparam int WOFF = 1;
`else
  localparam int WOFF = 0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [VOICES-1:0]    tone = '0;
  logic [VOICES-1:0]    gate = '0;
  logic                 pwm_out;
  logic [VOICES-1:0]    voice_active;
  logic [SUM_WIDTH-1:0] sample;

  voice_env_mixer #(
    .VOICES      (VOICES),
    .ENV_WIDTH   (ENV_WIDTH),
    .ENV_PRESCALE(ENV_PRESCALE),
    .PWM_WIDTH   (PWM_WIDTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tone        (tone),
    .gate        (gate),
    .pwm_out     (pwm_out),
    .voice_active(voice_active),
    .sample      (sample)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int                exp_va_q[$];
  int                exp_samp_q[$];
  int                exp_cnt_q[$];
  int                lvl [VOICES];

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Directed phases first (attack, release/reversal, full mix, silent mix), then random gates and tones.
  task automatic pick(input int s, inout logic [VOICES-1:0] g, output logic [VOICES-1:0] t);
    if (s < 122)      begin g = 4'b0001; t = 4'b0001; end
    else if (s < 127) begin g = 4'b0000; t = 4'b0001; end
    else if (s < 131) begin g = 4'b0001; t = 4'b0001; end
    else if (s < 192) begin g = 4'b0000; t = 4'b0001; end
    else if (s < 256) begin g = 4'b1111; t = 4'b1111; end
    else if (s < 320) begin g = 4'b1111; t = 4'b0000; end
    else begin
      for (int v = 0; v < VOICES; v++) begin
        if ($urandom_range(5) == 0) g[v] = ~g[v];
      end
      t = VOICES'($urandom);
    end
  endtask

  // Slot s starts at the negedge after envelope tick s; its gate sets tick s+1, and the
  // tone driven in the last slot of a period together with the current levels sets the next period's duty.
  task automatic drive();
    logic [VOICES-1:0] g, t;
    int                mix, va;
    g = '0;
    for (int v = 0; v < VOICES; v++) lvl[v] = 0;
    for (int s = 0; s < N_SLOTS; s++) begin
      pick(s, g, t);
      gate = g;
      tone = t;
      if (s % SPP == SPP - 1) begin
        mix = 0;
        for (int v = 0; v < VOICES; v++) if (t[v]) mix += lvl[v];
        exp_samp_q.push_back(mix);
        exp_cnt_q.push_back(mix * (PERIOD / (1 << SUM_WIDTH)));
      end
      va = 0;
      for (int v = 0; v < VOICES; v++) begin
        lvl[v] = g[v] ? ((lvl[v] < ENV_MAX) ? lvl[v] + 1 : ENV_MAX)
                      : ((lvl[v] > 0) ? lvl[v] - 1 : 0);
        if (lvl[v] != 0) va |= (1 << v);
      end
      exp_va_q.push_back(va);
      repeat (ENV_PRESCALE) @(negedge clk);
    end
  endtask

  task automatic monitor();
    int                hi;
    int                m;
    logic [VOICES-1:0] va_exp;
    hi = 0;
    va_exp = '0;
    for (int n = 0; n < N_CYCLES; n++) begin
      if (n > 0 && n % ENV_PRESCALE == 0 && n / ENV_PRESCALE <= N_SLOTS) begin
        if (exp_va_q.size() > 0) va_exp = VOICES'(exp_va_q.pop_front());
        else begin
          checks++;
          errors++;
          $display("FAIL va_queue_underflow at cycle %0d", n);
        end
      end
      if (n < (N_SLOTS + 1) * ENV_PRESCALE) check("voice_active", voice_active, va_exp);

      if (n / PERIOD <= N_PERIODS && exp_samp_q.size() > 0) begin
        if (n % PERIOD == 0)          check("sample_start", sample, exp_samp_q[0]);
        if (n % PERIOD == PERIOD - 1) check("sample_end", sample, exp_samp_q.pop_front());
      end

      m = n - WOFF;
      if (m >= 0 && m / PERIOD <= N_PERIODS) begin
        hi += int'(pwm_out);
        if (m % PERIOD == PERIOD - 1) begin
          if (exp_cnt_q.size() > 0) check("pwm_high_count", hi, exp_cnt_q.pop_front());
          hi = 0;
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tone = VOICES'($urandom);
      gate = VOICES'($urandom);
      @(negedge clk);
      check("rst_pwm_out", pwm_out, 0);
      check("rst_voice_active", voice_active, 0);
      check("rst_sample", sample, 0);
    end

    exp_samp_q.push_back(0);
    exp_cnt_q.push_back(0);
    rst_n = 1'b1;
    fork
      drive();
      monitor();
    join
    check("pending_expectations", exp_va_q.size() + exp_samp_q.size() + exp_cnt_q.size(), 0);

    gate = '1;
    tone = '1;
    repeat (2 * PERIOD + 10) @(negedge clk);
    check("full_mix_sample", sample, VOICES * ENV_MAX);
    check("full_mix_active", voice_active, (1 << VOICES) - 1);

    repeat (37) @(negedge clk);
    rst_n = 1'b0;
    tone  = VOICES'($urandom);
    gate  = VOICES'($urandom);
    @(negedge clk);
    check("midrun_rst_pwm_out", pwm_out, 0);
    check("midrun_rst_voice_active", voice_active, 0);
    check("midrun_rst_sample", sample, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
